// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register; define PIPE_STAGE_SKID_EN for the two-entry skid version with registered in_ready.
module pipe_stage_reg #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [CNT_W-1:0] stall_q;
  logic in_x, out_x, stall_inc;
  assign out_valid = state_q != EMPTY;
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_q;
  assign in_x      = in_valid & in_ready;
  assign out_x     = out_valid & out_ready;
  assign stall_inc = out_valid & ~out_ready & ~&stall_q;
`ifdef PIPE_STAGE_SKID_EN
  logic [WIDTH-1:0] skid_q, skid_d;
  logic rdy_q;
  assign in_ready = rdy_q;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: if (in_x) begin
          state_d = FULL;
          main_d  = in_data;
        end
        FULL: if (in_x && out_x) begin
          main_d = in_data;
        end else if (out_x) begin
          state_d = EMPTY;
        end else if (in_x) begin
          state_d = SKID;
          skid_d  = in_data;
        end
        SKID: if (out_ready) begin
          state_d = FULL;
          main_d  = skid_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end
  // in_ready comes from its own flop so upstream never sees out_ready combinationally
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_q <= '0;
      rdy_q  <= 1'b1;
    end else begin
      skid_q <= skid_d;
      rdy_q  <= state_d != SKID;
    end
  end
`else
  assign in_ready = ~out_valid | out_ready;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
    end else if (in_x) begin
      state_d = FULL;
      main_d  = in_data;
    end else if (out_x) begin
      state_d = EMPTY;
    end
  end
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      stall_q <= stall_q + CNT_W'(stall_inc);
    end
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench; held entries are modelled as a FIFO queue of accepted payloads.
module tb_pipe_stage_reg;
  localparam int WIDTH = 16;
  localparam int CNT_W = 4;
  localparam int MAXS  = (1 << CNT_W) - 1;
  logic clk = 1'b0;
  logic reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic in_ready, out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0] occupancy;
  logic [CNT_W-1:0] stall_cnt;
  logic [WIDTH-1:0] exp_q[$];
  int total = 0, bad = 0, stall_m = 0;
  bit run_mon = 0, zero_m = 1, acc = 0;
  logic [WIDTH-1:0] seq = '0;
  pipe_stage_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic bit model_rdy();
`ifdef PIPE_STAGE_SKID_EN
    return exp_q.size() < 2;
`else
    return exp_q.size() == 0 || out_ready;
`endif
  endfunction
  // monitor: compares DUT against the queue model, then retires this cycle's effects
  always @(negedge clk) begin
    #3;
    if (run_mon) begin
      chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("out_data", 64'(out_data), 64'(exp_q[0]));
      else if (zero_m) chk("out_data_zero", 64'(out_data), 64'd0);
      chk("in_ready", 64'(in_ready), 64'(model_rdy()));
      chk("stall_cnt", 64'(stall_cnt), 64'(stall_m));
      if (reset) begin
        exp_q.delete();
        stall_m = 0;
        zero_m = 1;
      end else begin
        if (exp_q.size() != 0 && !out_ready && stall_m < MAXS) stall_m++;
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        if (flush) begin
          exp_q.delete();
          zero_m = 1;
        end
      end
    end
  end
  task automatic step(input logic r, input logic f, input logic v, input logic [WIDTH-1:0] d, input logic o);
    @(negedge clk);
    reset = r;
    flush = f;
    in_valid = v;
    in_data = d;
    out_ready = o;
    #4;
    acc = !r && !f && v && in_ready === 1'b1;
    if (acc) begin
      exp_q.push_back(d);
      zero_m = 0;
    end
  endtask
  initial begin
    step(1, 0, 0, '0, 0);
    step(1, 0, 0, '0, 0);
    run_mon = 1;
    step(0, 0, 1, 16'h1234, 1);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);
    step(0, 0, 1, 16'h000A, 0);
    step(0, 0, 1, 16'h000B, 0);
    step(0, 0, 1, 16'h000D, 0);
    repeat (3) step(0, 0, 0, '0, 1);
    step(0, 0, 1, 16'h0001, 0);
    step(0, 0, 1, 16'h0002, 0);
    step(0, 1, 1, 16'h000C, 0);
    repeat (2) step(0, 0, 0, '0, 0);
    step(0, 0, 1, 16'h0005, 0);
    repeat (20) step(0, 0, 0, '0, 0);
    step(0, 1, 0, '0, 0);
    step(0, 0, 0, '0, 0);
    step(0, 0, 1, 16'h0007, 1);
    step(1, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);
    for (int i = 0; i < 6000; i++) begin
      step($urandom_range(0, 999) == 0, $urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)), seq, 1'($urandom_range(0, 1)));
      if (acc) seq++;
    end
    repeat (4) step(0, 0, 0, '0, 1);
    @(negedge clk);
    #5;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
